// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with load/shift handshake
// Two-state FSM; a word loads in IDLE or in the last-bit cycle for gapless back-to-back words.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_load_ready,
  input  logic             i_shift_en,
  output logic             o_dout,
  output logic             o_dout_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic w_in_shift;
  logic w_last;
  logic w_out_bit;

  assign w_in_shift = (r_state == SHIFT);
  assign w_last     = w_in_shift && i_shift_en && (r_cnt == LAST_CNT);
  assign w_out_bit  = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

  // Ready depends only on registered state and shift_en, never on load_valid/din.
  assign o_load_ready = (r_state == IDLE) || w_last;
  assign o_dout       = w_in_shift ? w_out_bit : 1'b0;
  assign o_dout_valid = w_in_shift;
  assign o_busy       = w_in_shift;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load_valid) begin
            r_sreg  <= i_din;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_shift_en) begin
            if (r_cnt == LAST_CNT) begin
              r_done <= 1'b1;
              if (i_load_valid) begin
                r_sreg <= i_din;
                r_cnt  <= '0;
              end else begin
                r_sreg  <= '0;
                r_cnt   <= '0;
                r_state <= IDLE;
              end
            end else begin
              if (MSB_FIRST) begin
                r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
              end else begin
                r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
              end
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the clk rising edge only.
REQ-005 load_valid  input  1  parallel word on din offered for loading.
REQ-006 din  input  WIDTH  parallel word; sampled only on an accepted load.
REQ-007 load_ready  output  1  block can accept din this cycle; load accepted when load_valid && load_ready at the clk edge.
REQ-008 shift_en  input  1  consumer takes the presented bit this cycle; advances the serializer.
REQ-009 dout  output  1  current serial bit.
REQ-010 dout_valid  output  1  dout carries a valid data bit.
REQ-011 busy  output  1  a word is being serialized.
REQ-012 done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT, plus a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 IDLE: dout=0, dout_valid=0, busy=0, load_ready=1.
REQ-015 IDLE with load_valid=1: shift register <= din, counter <= 0, next state SHIFT; first bit appears on dout the following cycle (1-cycle load latency).
REQ-016 SHIFT: dout = shift register bit WIDTH-1 if MSB_FIRST=1, else bit 0; dout_valid=1, busy=1.
REQ-017 SHIFT, shift_en=1, counter < WIDTH-1: shift register shifts one position toward the output end, zero fill; counter increments.
REQ-018 SHIFT, shift_en=0: shift register, counter and dout SHALL hold unchanged for any stall length.
REQ-019 SHIFT, shift_en=1, counter = WIDTH-1 (last bit): done <= 1 for the next cycle only.
REQ-020 In the last-bit cycle of REQ-019, load_ready SHALL be 1; if load_valid=1 the new word loads, counter <= 0, state stays SHIFT (zero-gap back-to-back words); otherwise next state IDLE.
REQ-021 load_ready SHALL be 0 in every other SHIFT cycle; load_valid asserted then SHALL be ignored and din not sampled.
REQ-022 load_ready = (state==IDLE) || (state==SHIFT && shift_en && counter==WIDTH-1); combinational from registered state and shift_en only, no path from load_valid or din.
REQ-023 dout, dout_valid, busy SHALL be functions of registered state only (no combinational path from any input).
REQ-024 done SHALL be registered and never asserted for two consecutive cycles unless WIDTH consecutive bits... are not possible; with WIDTH>=2 done is always isolated.
REQ-025 Exactly WIDTH bits SHALL be emitted per accepted word; bits are never dropped or duplicated across stalls.

Reset
REQ-026 With reset=1 at a clk edge: state <= IDLE, shift register <= 0, counter <= 0, done <= 0; resulting outputs dout=0, dout_valid=0, busy=0, load_ready=1, done=0.
REQ-027 reset SHALL take priority over load_valid and shift_en in the same cycle; a word in progress is discarded and no done pulse is generated for it.
REQ-028 A load presented in the cycle reset is asserted SHALL NOT be accepted.

Verification
REQ-029 WIDTH=4, MSB_FIRST=1, reset 1 cycle, load 4'b1011, shift_en=1 constant -> dout 1,0,1,1 on cycles 1-4 after accept with dout_valid=1, done=1 on cycle 5, then IDLE with dout=0.
REQ-030 MSB_FIRST=0, load 4'b1011, shift_en=1 -> dout 1,1,0,1; done on cycle 5.
REQ-031 MSB_FIRST=1, load 4'b1011, shift_en=0 for 3 cycles after 2nd bit -> dout holds 0 and dout_valid=1 through the stall, remaining bits 1,1, total 4 bits, single done pulse.
REQ-032 load_valid held with 4'b1011 then 4'b0110, shift_en=1 -> 8 contiguous bits 1,0,1,1,0,1,1,0, no idle gap, load_ready=1 only on bit 4 cycle, done pulses at cycles 5 and 9.
REQ-033 load 4'b1011, assert reset after 2 bits consumed -> next cycle IDLE, dout=0, dout_valid=0, busy=0, no done pulse.
REQ-034 load_valid=1 with 4'b0000 during 2nd bit of word 4'b1011 -> load_ready=0, ignored, word completes as 1,0,1,1.
